cv32e40p_wb_trace_capture: RTL

//  Consumer of the core's internal write-back signals. Samples both register-file write ports each cycle:
//  - ALU forward port (regfile_alu_*_fw)
//  - LSU/WB port (regfile_we_wb / regfile_waddr_fw_wb_o / regfile_wdata)

---
 rtl/cv32e40p_wb_trace_capture.sv | 103 ++++++++++
 1 files changed

// File: rtl/cv32e40p_wb_trace_capture.sv
// Write-back trace capture: time-stamps register-file writes from the ALU and WB
// ports, queues them in a small FIFO and drains them as a valid/ready record stream.
module cv32e40p_wb_trace_capture #(
  parameter int DEPTH     = 8,
  parameter int TS_W      = 16,
  parameter int FILTER_X0 = 1,
  parameter int DROP_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       regfile_alu_we_fw,
  input  logic [5:0]                 regfile_alu_waddr_fw,
  input  logic [31:0]                regfile_alu_wdata_fw,
  input  logic                       regfile_we_wb,
  input  logic [5:0]                 regfile_waddr_fw_wb_o,
  input  logic [31:0]                regfile_wdata,
  output logic                       trace_valid_o,
  input  logic                       trace_ready_i,
  output logic [TS_W+38:0]           trace_rec_o,
  output logic [$clog2(DEPTH):0]     fill_level_o,
  output logic                       overflow_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef logic [TS_W+38:0] rec_t;

  logic [TS_W-1:0] ts_q;
  rec_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   fill_q, free;
  logic            ev_wb, ev_alu, pop;
  logic [1:0]      n_ev, n_push, n_drop;
  rec_t            wb_rec, alu_rec, push0_rec;
  logic [DROP_W:0] drop_sum;

  assign ev_wb  = en_i & regfile_we_wb &
                  ~((FILTER_X0 != 0) && (regfile_waddr_fw_wb_o == 6'd0));
  assign ev_alu = en_i & regfile_alu_we_fw &
                  ~((FILTER_X0 != 0) && (regfile_alu_waddr_fw == 6'd0));

  assign wb_rec  = {ts_q, 1'b1, regfile_waddr_fw_wb_o, regfile_wdata};
  assign alu_rec = {ts_q, 1'b0, regfile_alu_waddr_fw, regfile_alu_wdata_fw};

  // Room is judged on the start-of-cycle occupancy; a concurrent pop frees nothing.
  assign free          = LW'(DEPTH) - fill_q;
  assign trace_valid_o = (fill_q != '0);
  assign pop           = trace_valid_o & trace_ready_i;
  assign trace_rec_o   = trace_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fill_level_o  = fill_q;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    n_ev      = {1'b0, ev_wb} + {1'b0, ev_alu};
    n_push    = 2'd0;
    push0_rec = ev_wb ? wb_rec : alu_rec;
    if (free >= LW'(2))      n_push = n_ev;
    else if (free == LW'(1)) n_push = (n_ev != 2'd0) ? 2'd1 : 2'd0;
    n_drop   = n_ev - n_push;
    drop_sum = {1'b0, drop_cnt_o} + (DROP_W+1)'(n_drop);
  end

  // WB is older, so it always takes the first slot; ALU is the one dropped when short.
  // NOTE: storage has no reset; stale entries are never visible because the output is gated by valid.
  always_ff @(posedge clk_i) begin
    if (!flush_i && n_push != 2'd0) mem_q[wr_ptr_q] <= push0_rec;
    if (!flush_i && n_push == 2'd2) mem_q[wr_ptr_q + PW'(1)] <= alu_rec;
  end

  // NOTE: state registers use non-blocking assignment so all updates see start-of-cycle values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (flush_i) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fill_q     <= '0;
        overflow_o <= 1'b0;
        drop_cnt_o <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_q + PW'(n_push);
        rd_ptr_q <= rd_ptr_q + PW'(pop);
        fill_q   <= fill_q + LW'(n_push) - LW'(pop);
        if (n_drop != 2'd0) begin
          overflow_o <= 1'b1;
          drop_cnt_o <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
      end
    end
  end

endmodule
